// File: rtl/nvdla_host_mem_adapter_if.sv
// DBB-side request/response bus and host-memory AXI4 master bus for nvdla_host_mem_adapter.
// valid/ready: a beat transfers on a rising edge where both are high; a raised valid holds with its payload until that edge.
interface nvdla_host_mem_adapter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  dla_ar_valid;
    logic                  dla_ar_ready;
    logic [ID_WIDTH-1:0]   dla_ar_id;
    logic [7:0]            dla_ar_len;
    logic [ADDR_WIDTH-1:0] dla_ar_addr;
    logic                  dla_aw_valid;
    logic                  dla_aw_ready;
    logic [ID_WIDTH-1:0]   dla_aw_id;
    logic [7:0]            dla_aw_len;
    logic [ADDR_WIDTH-1:0] dla_aw_addr;
    logic                  dla_w_valid;
    logic                  dla_w_ready;
    logic [DATA_WIDTH-1:0] dla_w_data;
    logic [STRB_WIDTH-1:0] dla_w_strb;
    logic                  dla_w_last;
    logic                  dla_b_valid;
    logic                  dla_b_ready;
    logic [ID_WIDTH-1:0]   dla_b_id;
    logic                  dla_r_valid;
    logic                  dla_r_ready;
    logic [ID_WIDTH-1:0]   dla_r_id;
    logic                  dla_r_last;
    logic [DATA_WIDTH-1:0] dla_r_data;

    logic                  m_axi_host_mem_awvalid;
    logic                  m_axi_host_mem_awready;
    logic [ID_WIDTH-1:0]   m_axi_host_mem_awid;
    logic [ADDR_WIDTH-1:0] m_axi_host_mem_awaddr;
    logic [7:0]            m_axi_host_mem_awlen;
    logic [2:0]            m_axi_host_mem_awsize;
    logic [1:0]            m_axi_host_mem_awburst;
    logic                  m_axi_host_mem_awlock;
    logic [3:0]            m_axi_host_mem_awcache;
    logic [2:0]            m_axi_host_mem_awprot;
    logic [3:0]            m_axi_host_mem_awqos;
    logic [3:0]            m_axi_host_mem_awregion;
    logic [USER_WIDTH-1:0] m_axi_host_mem_awuser;
    logic                  m_axi_host_mem_wvalid;
    logic                  m_axi_host_mem_wready;
    logic [DATA_WIDTH-1:0] m_axi_host_mem_wdata;
    logic [STRB_WIDTH-1:0] m_axi_host_mem_wstrb;
    logic                  m_axi_host_mem_wlast;
    logic [USER_WIDTH-1:0] m_axi_host_mem_wuser;
    logic                  m_axi_host_mem_bvalid;
    logic                  m_axi_host_mem_bready;
    logic [ID_WIDTH-1:0]   m_axi_host_mem_bid;
    logic [1:0]            m_axi_host_mem_bresp;
    logic                  m_axi_host_mem_arvalid;
    logic                  m_axi_host_mem_arready;
    logic [ID_WIDTH-1:0]   m_axi_host_mem_arid;
    logic [ADDR_WIDTH-1:0] m_axi_host_mem_araddr;
    logic [7:0]            m_axi_host_mem_arlen;
    logic [2:0]            m_axi_host_mem_arsize;
    logic [1:0]            m_axi_host_mem_arburst;
    logic                  m_axi_host_mem_arlock;
    logic [3:0]            m_axi_host_mem_arcache;
    logic [2:0]            m_axi_host_mem_arprot;
    logic [3:0]            m_axi_host_mem_arqos;
    logic [3:0]            m_axi_host_mem_arregion;
    logic [USER_WIDTH-1:0] m_axi_host_mem_aruser;
    logic                  m_axi_host_mem_rvalid;
    logic                  m_axi_host_mem_rready;
    logic [ID_WIDTH-1:0]   m_axi_host_mem_rid;
    logic [DATA_WIDTH-1:0] m_axi_host_mem_rdata;
    logic [1:0]            m_axi_host_mem_rresp;
    logic                  m_axi_host_mem_rlast;

    // The adapter: slave toward the DBB, AXI master toward host memory.
    modport master (
        input  dla_ar_valid, dla_ar_id, dla_ar_len, dla_ar_addr,
        output dla_ar_ready,
        input  dla_aw_valid, dla_aw_id, dla_aw_len, dla_aw_addr,
        output dla_aw_ready,
        input  dla_w_valid, dla_w_data, dla_w_strb, dla_w_last,
        output dla_w_ready,
        output dla_b_valid, dla_b_id,
        input  dla_b_ready,
        output dla_r_valid, dla_r_id, dla_r_last, dla_r_data,
        input  dla_r_ready,
        output m_axi_host_mem_awvalid, m_axi_host_mem_awid, m_axi_host_mem_awaddr,
        output m_axi_host_mem_awlen, m_axi_host_mem_awsize, m_axi_host_mem_awburst,
        output m_axi_host_mem_awlock, m_axi_host_mem_awcache, m_axi_host_mem_awprot,
        output m_axi_host_mem_awqos, m_axi_host_mem_awregion, m_axi_host_mem_awuser,
        input  m_axi_host_mem_awready,
        output m_axi_host_mem_wvalid, m_axi_host_mem_wdata, m_axi_host_mem_wstrb,
        output m_axi_host_mem_wlast, m_axi_host_mem_wuser,
        input  m_axi_host_mem_wready,
        input  m_axi_host_mem_bvalid, m_axi_host_mem_bid, m_axi_host_mem_bresp,
        output m_axi_host_mem_bready,
        output m_axi_host_mem_arvalid, m_axi_host_mem_arid, m_axi_host_mem_araddr,
        output m_axi_host_mem_arlen, m_axi_host_mem_arsize, m_axi_host_mem_arburst,
        output m_axi_host_mem_arlock, m_axi_host_mem_arcache, m_axi_host_mem_arprot,
        output m_axi_host_mem_arqos, m_axi_host_mem_arregion, m_axi_host_mem_aruser,
        input  m_axi_host_mem_arready,
        input  m_axi_host_mem_rvalid, m_axi_host_mem_rid, m_axi_host_mem_rdata,
        input  m_axi_host_mem_rresp, m_axi_host_mem_rlast,
        output m_axi_host_mem_rready
    );

    // The surroundings: DBB master plus host-memory slave.
    modport slave (
        output dla_ar_valid, dla_ar_id, dla_ar_len, dla_ar_addr,
        input  dla_ar_ready,
        output dla_aw_valid, dla_aw_id, dla_aw_len, dla_aw_addr,
        input  dla_aw_ready,
        output dla_w_valid, dla_w_data, dla_w_strb, dla_w_last,
        input  dla_w_ready,
        input  dla_b_valid, dla_b_id,
        output dla_b_ready,
        input  dla_r_valid, dla_r_id, dla_r_last, dla_r_data,
        output dla_r_ready,
        input  m_axi_host_mem_awvalid, m_axi_host_mem_awid, m_axi_host_mem_awaddr,
        input  m_axi_host_mem_awlen, m_axi_host_mem_awsize, m_axi_host_mem_awburst,
        input  m_axi_host_mem_awlock, m_axi_host_mem_awcache, m_axi_host_mem_awprot,
        input  m_axi_host_mem_awqos, m_axi_host_mem_awregion, m_axi_host_mem_awuser,
        output m_axi_host_mem_awready,
        input  m_axi_host_mem_wvalid, m_axi_host_mem_wdata, m_axi_host_mem_wstrb,
        input  m_axi_host_mem_wlast, m_axi_host_mem_wuser,
        output m_axi_host_mem_wready,
        output m_axi_host_mem_bvalid, m_axi_host_mem_bid, m_axi_host_mem_bresp,
        input  m_axi_host_mem_bready,
        input  m_axi_host_mem_arvalid, m_axi_host_mem_arid, m_axi_host_mem_araddr,
        input  m_axi_host_mem_arlen, m_axi_host_mem_arsize, m_axi_host_mem_arburst,
        input  m_axi_host_mem_arlock, m_axi_host_mem_arcache, m_axi_host_mem_arprot,
        input  m_axi_host_mem_arqos, m_axi_host_mem_arregion, m_axi_host_mem_aruser,
        output m_axi_host_mem_arready,
        output m_axi_host_mem_rvalid, m_axi_host_mem_rid, m_axi_host_mem_rdata,
        output m_axi_host_mem_rresp, m_axi_host_mem_rlast,
        input  m_axi_host_mem_rready
    );
endinterface

// File: rtl/nvdla_host_mem_adapter.sv
// Bridges the NVDLA DBB master onto the host-memory AXI4 port: rebased, registered AR/AW,
// pass-through W/R/B, outstanding-transaction throttle and sticky response-error flag.
module nvdla_host_mem_adapter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 1,
    parameter int USER_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  cfg_enable,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [USER_WIDTH-1:0] cfg_ctx,
    input  logic                  err_clr,
    output logic                  busy,
    output logic                  err_resp,
    output logic [CNT_WIDTH-1:0]  rd_outstanding,
    output logic [CNT_WIDTH-1:0]  wr_outstanding,
    nvdla_host_mem_adapter_if.master bus
);
    localparam logic [2:0]         AXI_SIZE  = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [CNT_WIDTH:0] MAX_CNT   = (CNT_WIDTH + 1)'(MAX_OUTSTANDING);

    logic                  ar_q_valid, aw_q_valid;
    logic [ID_WIDTH-1:0]   ar_q_id, aw_q_id;
    logic [7:0]            ar_q_len, aw_q_len;
    logic [ADDR_WIDTH-1:0] ar_q_addr, aw_q_addr;
    logic [USER_WIDTH-1:0] ar_q_user, aw_q_user;
    logic [CNT_WIDTH-1:0]  rd_cnt, wr_cnt;
    logic [CNT_WIDTH:0]    rd_load, wr_load;
    logic                  ar_accept, aw_accept, ar_load, aw_load, ar_issue, aw_issue;
    logic                  r_done, b_done, err_event;

    // A request sitting in the slice counts against the cap so the counter cannot overshoot.
    assign rd_load   = {1'b0, rd_cnt} + {{CNT_WIDTH{1'b0}}, ar_q_valid};
    assign wr_load   = {1'b0, wr_cnt} + {{CNT_WIDTH{1'b0}}, aw_q_valid};
    assign ar_accept = cfg_enable && (!ar_q_valid || bus.m_axi_host_mem_arready) && (rd_load < MAX_CNT);
    assign aw_accept = cfg_enable && (!aw_q_valid || bus.m_axi_host_mem_awready) && (wr_load < MAX_CNT);
    assign ar_load   = bus.dla_ar_valid && ar_accept;
    assign aw_load   = bus.dla_aw_valid && aw_accept;
    assign ar_issue  = ar_q_valid && bus.m_axi_host_mem_arready;
    assign aw_issue  = aw_q_valid && bus.m_axi_host_mem_awready;
    assign r_done    = bus.m_axi_host_mem_rvalid && bus.dla_r_ready && bus.m_axi_host_mem_rlast;
    assign b_done    = bus.m_axi_host_mem_bvalid && bus.dla_b_ready;
    assign err_event = (b_done && (bus.m_axi_host_mem_bresp != 2'b00)) ||
                       (bus.m_axi_host_mem_rvalid && bus.dla_r_ready && (bus.m_axi_host_mem_rresp != 2'b00));

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ar_q_valid <= 1'b0;
            ar_q_id    <= '0;
            ar_q_len   <= '0;
            ar_q_addr  <= '0;
            ar_q_user  <= '0;
        end else if (ar_load) begin
            ar_q_valid <= 1'b1;
            ar_q_id    <= bus.dla_ar_id;
            ar_q_len   <= bus.dla_ar_len;
            ar_q_addr  <= bus.dla_ar_addr + cfg_base_addr;
            ar_q_user  <= cfg_ctx;
        end else if (ar_issue) begin
            ar_q_valid <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            aw_q_valid <= 1'b0;
            aw_q_id    <= '0;
            aw_q_len   <= '0;
            aw_q_addr  <= '0;
            aw_q_user  <= '0;
        end else if (aw_load) begin
            aw_q_valid <= 1'b1;
            aw_q_id    <= bus.dla_aw_id;
            aw_q_len   <= bus.dla_aw_len;
            aw_q_addr  <= bus.dla_aw_addr + cfg_base_addr;
            aw_q_user  <= cfg_ctx;
        end else if (aw_issue) begin
            aw_q_valid <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            err_resp <= 1'b0;
        end else begin
            if (ar_issue && !r_done) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else if (!ar_issue && r_done) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (aw_issue && !b_done) begin
                wr_cnt <= wr_cnt + 1'b1;
            end else if (!aw_issue && b_done) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
            // A new error in the clearing cycle must not be lost.
            if (err_event) begin
                err_resp <= 1'b1;
            end else if (err_clr) begin
                err_resp <= 1'b0;
            end
        end
    end

    assign rd_outstanding = rd_cnt;
    assign wr_outstanding = wr_cnt;
    assign busy           = ar_q_valid | aw_q_valid | (rd_cnt != '0) | (wr_cnt != '0);
    assign bus.dla_ar_ready = ar_accept;
    assign bus.dla_aw_ready = aw_accept;

    assign bus.m_axi_host_mem_arvalid  = ar_q_valid;
    assign bus.m_axi_host_mem_arid     = ar_q_id;
    assign bus.m_axi_host_mem_araddr   = ar_q_addr;
    assign bus.m_axi_host_mem_arlen    = ar_q_len;
    assign bus.m_axi_host_mem_arsize   = AXI_SIZE;
    assign bus.m_axi_host_mem_arburst  = 2'b01;
    assign bus.m_axi_host_mem_arlock   = 1'b0;
    assign bus.m_axi_host_mem_arcache  = 4'b0011;
    assign bus.m_axi_host_mem_arprot   = 3'b000;
    assign bus.m_axi_host_mem_arqos    = 4'b0000;
    assign bus.m_axi_host_mem_arregion = 4'b0000;
    assign bus.m_axi_host_mem_aruser   = ar_q_user;

    assign bus.m_axi_host_mem_awvalid  = aw_q_valid;
    assign bus.m_axi_host_mem_awid     = aw_q_id;
    assign bus.m_axi_host_mem_awaddr   = aw_q_addr;
    assign bus.m_axi_host_mem_awlen    = aw_q_len;
    assign bus.m_axi_host_mem_awsize   = AXI_SIZE;
    assign bus.m_axi_host_mem_awburst  = 2'b01;
    assign bus.m_axi_host_mem_awlock   = 1'b0;
    assign bus.m_axi_host_mem_awcache  = 4'b0011;
    assign bus.m_axi_host_mem_awprot   = 3'b000;
    assign bus.m_axi_host_mem_awqos    = 4'b0000;
    assign bus.m_axi_host_mem_awregion = 4'b0000;
    assign bus.m_axi_host_mem_awuser   = aw_q_user;

    assign bus.m_axi_host_mem_wvalid = bus.dla_w_valid;
    assign bus.m_axi_host_mem_wdata  = bus.dla_w_data;
    assign bus.m_axi_host_mem_wstrb  = bus.dla_w_strb;
    assign bus.m_axi_host_mem_wlast  = bus.dla_w_last;
    assign bus.m_axi_host_mem_wuser  = '0;
    assign bus.dla_w_ready           = bus.m_axi_host_mem_wready;

    assign bus.dla_b_valid           = bus.m_axi_host_mem_bvalid;
    assign bus.dla_b_id              = bus.m_axi_host_mem_bid;
    assign bus.m_axi_host_mem_bready = bus.dla_b_ready;

    assign bus.dla_r_valid           = bus.m_axi_host_mem_rvalid;
    assign bus.dla_r_id              = bus.m_axi_host_mem_rid;
    assign bus.dla_r_last            = bus.m_axi_host_mem_rlast;
    assign bus.dla_r_data            = bus.m_axi_host_mem_rdata;
    assign bus.m_axi_host_mem_rready = bus.dla_r_ready;
endmodule

// File: tb/tb_nvdla_host_mem_adapter.sv
// Self-checking bench for nvdla_host_mem_adapter: directed scenarios plus randomized read traffic
// against a queue-based model of the request slice and in-flight count.
module tb_nvdla_host_mem_adapter;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int MAXO = 16;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          cfg_enable;
    logic [AW-1:0] cfg_base_addr;
    logic [7:0]    cfg_ctx;
    logic          err_clr;
    logic          busy;
    logic          err_resp;
    logic [4:0]    rd_outstanding;
    logic [4:0]    wr_outstanding;
    int            n_cmp;
    int            n_err;

    nvdla_host_mem_adapter_if bus ();

    nvdla_host_mem_adapter dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .cfg_enable     (cfg_enable),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_ctx        (cfg_ctx),
        .err_clr        (err_clr),
        .busy           (busy),
        .err_resp       (err_resp),
        .rd_outstanding (rd_outstanding),
        .wr_outstanding (wr_outstanding),
        .bus            (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        ap_rst_n = 1'b0; cfg_enable = 1'b0; cfg_base_addr = '0; cfg_ctx = '0; err_clr = 1'b0;
        bus.dla_ar_valid = 0; bus.dla_ar_id = '0; bus.dla_ar_len = '0; bus.dla_ar_addr = '0;
        bus.dla_aw_valid = 0; bus.dla_aw_id = '0; bus.dla_aw_len = '0; bus.dla_aw_addr = '0;
        bus.dla_w_valid = 0; bus.dla_w_data = '0; bus.dla_w_strb = '0; bus.dla_w_last = 0;
        bus.dla_b_ready = 0; bus.dla_r_ready = 0;
        bus.m_axi_host_mem_awready = 0; bus.m_axi_host_mem_wready = 0; bus.m_axi_host_mem_arready = 0;
        bus.m_axi_host_mem_bvalid = 0; bus.m_axi_host_mem_bid = '0; bus.m_axi_host_mem_bresp = '0;
        bus.m_axi_host_mem_rvalid = 0; bus.m_axi_host_mem_rid = '0; bus.m_axi_host_mem_rdata = '0;
        bus.m_axi_host_mem_rresp = '0; bus.m_axi_host_mem_rlast = 0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        cfg_enable = 1'b0;
        repeat (3) @(negedge ap_clk);
        n_cmp++;
        if ({bus.m_axi_host_mem_arvalid, bus.m_axi_host_mem_awvalid, bus.dla_ar_ready, bus.dla_aw_ready, busy, err_resp} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000", {bus.m_axi_host_mem_arvalid, bus.m_axi_host_mem_awvalid, bus.dla_ar_ready, bus.dla_aw_ready, busy, err_resp});
        end
        n_cmp++;
        if ({rd_outstanding, wr_outstanding} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_outstanding, wr_outstanding);
        end
        n_cmp++;
        if ({bus.m_axi_host_mem_araddr, bus.m_axi_host_mem_awaddr, bus.m_axi_host_mem_arlen, bus.m_axi_host_mem_awlen, bus.m_axi_host_mem_arid} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got araddr=%h awaddr=%h want 0", bus.m_axi_host_mem_araddr, bus.m_axi_host_mem_awaddr);
        end
        cfg_enable = 1'b1;
        #1;
        n_cmp++;
        if ({bus.dla_ar_ready, bus.dla_aw_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_ready_enabled: got %b want 11", {bus.dla_ar_ready, bus.dla_aw_ready});
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_read_basic();
        logic [DW-1:0] beat;
        cfg_base_addr = 64'h1000_0000_0000;
        cfg_ctx = 8'h5A;
        bus.m_axi_host_mem_arready = 1'b1;
        bus.dla_r_ready = 1'b1;
        @(negedge ap_clk);
        bus.dla_ar_valid = 1'b1; bus.dla_ar_id = 1'b1; bus.dla_ar_len = 8'd3; bus.dla_ar_addr = 64'h40;
        #1;
        n_cmp++;
        if (bus.dla_ar_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rd_basic_ar_ready: got %b want 1", bus.dla_ar_ready);
        end
        @(negedge ap_clk);
        bus.dla_ar_valid = 1'b0;
        n_cmp++;
        if ({bus.m_axi_host_mem_arvalid, bus.m_axi_host_mem_araddr} !== {1'b1, 64'h1000_0000_0040}) begin
            n_err++;
            $display("FAIL rd_basic_araddr: got v=%b a=%h want v=1 a=100000000040", bus.m_axi_host_mem_arvalid, bus.m_axi_host_mem_araddr);
        end
        n_cmp++;
        if ({bus.m_axi_host_mem_arlen, bus.m_axi_host_mem_arsize, bus.m_axi_host_mem_arburst, bus.m_axi_host_mem_arcache, bus.m_axi_host_mem_aruser, bus.m_axi_host_mem_arid}
            !== {8'd3, 3'd6, 2'b01, 4'b0011, 8'h5A, 1'b1}) begin
            n_err++;
            $display("FAIL rd_basic_fields: got len=%0d size=%0d burst=%0d cache=%h user=%h id=%b want 3/6/1/3/5a/1",
                     bus.m_axi_host_mem_arlen, bus.m_axi_host_mem_arsize, bus.m_axi_host_mem_arburst,
                     bus.m_axi_host_mem_arcache, bus.m_axi_host_mem_aruser, bus.m_axi_host_mem_arid);
        end
        n_cmp++;
        if ({bus.m_axi_host_mem_arlock, bus.m_axi_host_mem_arprot, bus.m_axi_host_mem_arqos, bus.m_axi_host_mem_arregion, busy} !== {12'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rd_basic_zero_fields: got lock/prot/qos/region/busy=%h want 0001", {bus.m_axi_host_mem_arlock, bus.m_axi_host_mem_arprot, bus.m_axi_host_mem_arqos, bus.m_axi_host_mem_arregion, busy});
        end
        @(negedge ap_clk);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < DW / 32; k++) beat[k*32 +: 32] = $urandom;
            n_cmp++;
            if ({bus.m_axi_host_mem_arvalid, rd_outstanding} !== {1'b0, 5'd1}) begin
                n_err++;
                $display("FAIL rd_basic_inflight: got v=%b rd=%0d want v=0 rd=1", bus.m_axi_host_mem_arvalid, rd_outstanding);
            end
            bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rdata = beat;
            bus.m_axi_host_mem_rlast = (i == 3); bus.m_axi_host_mem_rresp = 2'b00; bus.m_axi_host_mem_rid = 1'b1;
            #1;
            n_cmp++;
            if ({bus.dla_r_valid, bus.dla_r_last, bus.dla_r_id, bus.m_axi_host_mem_rready, bus.dla_r_data} !== {1'b1, (i == 3), 1'b1, 1'b1, beat}) begin
                n_err++;
                $display("FAIL rd_basic_rbeat%0d: got v=%b last=%b id=%b rready=%b data_ok=%b", i,
                         bus.dla_r_valid, bus.dla_r_last, bus.dla_r_id, bus.m_axi_host_mem_rready, bus.dla_r_data === beat);
            end
            @(negedge ap_clk);
        end
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rlast = 1'b0;
        n_cmp++;
        if ({rd_outstanding, busy} !== {5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rd_basic_drained: got rd=%0d busy=%b want 0/0", rd_outstanding, busy);
        end
    endtask

    task automatic test_wrap_backpressure();
        logic [DW-1:0] wd;
        cfg_base_addr = 64'hFFFF_FFFF_FFFF_FFC0;
        bus.m_axi_host_mem_awready = 1'b0;
        @(negedge ap_clk);
        bus.dla_aw_valid = 1'b1; bus.dla_aw_addr = 64'h80; bus.dla_aw_len = 8'd0; bus.dla_aw_id = 1'b0;
        @(negedge ap_clk);
        n_cmp++;
        if ({bus.m_axi_host_mem_awvalid, bus.m_axi_host_mem_awaddr, bus.m_axi_host_mem_awsize, bus.m_axi_host_mem_awburst} !== {1'b1, 64'h40, 3'd6, 2'b01}) begin
            n_err++;
            $display("FAIL wrap_awaddr: got v=%b a=%h size=%0d burst=%0d want 1/40/6/1", bus.m_axi_host_mem_awvalid, bus.m_axi_host_mem_awaddr, bus.m_axi_host_mem_awsize, bus.m_axi_host_mem_awburst);
        end
        bus.dla_aw_addr = 64'h100;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if ({bus.dla_aw_ready, bus.m_axi_host_mem_awvalid, bus.m_axi_host_mem_awaddr} !== {1'b0, 1'b1, 64'h40}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got ready=%b v=%b a=%h want 0/1/40", i, bus.dla_aw_ready, bus.m_axi_host_mem_awvalid, bus.m_axi_host_mem_awaddr);
            end
            @(negedge ap_clk);
        end
        bus.m_axi_host_mem_awready = 1'b1;
        #1;
        n_cmp++;
        if (bus.dla_aw_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 1", bus.dla_aw_ready);
        end
        @(negedge ap_clk);
        bus.dla_aw_valid = 1'b0;
        n_cmp++;
        if ({bus.m_axi_host_mem_awvalid, bus.m_axi_host_mem_awaddr, wr_outstanding} !== {1'b1, 64'hC0, 5'd1}) begin
            n_err++;
            $display("FAIL bp_second_aw: got v=%b a=%h wr=%0d want 1/c0/1", bus.m_axi_host_mem_awvalid, bus.m_axi_host_mem_awaddr, wr_outstanding);
        end
        for (int k = 0; k < DW / 32; k++) wd[k*32 +: 32] = $urandom;
        bus.dla_w_valid = 1'b1; bus.dla_w_data = wd; bus.dla_w_strb = {2{$urandom}}; bus.dla_w_last = 1'b1;
        bus.m_axi_host_mem_wready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.m_axi_host_mem_wvalid, bus.m_axi_host_mem_wlast, bus.dla_w_ready, bus.m_axi_host_mem_wuser, bus.m_axi_host_mem_wdata, bus.m_axi_host_mem_wstrb}
            !== {1'b1, 1'b1, 1'b1, 8'h00, wd, bus.dla_w_strb}) begin
            n_err++;
            $display("FAIL w_passthrough: got v=%b last=%b ready=%b wuser=%h data_ok=%b", bus.m_axi_host_mem_wvalid, bus.m_axi_host_mem_wlast, bus.dla_w_ready, bus.m_axi_host_mem_wuser, bus.m_axi_host_mem_wdata === wd);
        end
        @(negedge ap_clk);
        bus.dla_w_valid = 1'b0; bus.dla_w_last = 1'b0; bus.m_axi_host_mem_wready = 1'b0;
        n_cmp++;
        if ({bus.m_axi_host_mem_awvalid, wr_outstanding} !== {1'b0, 5'd2}) begin
            n_err++;
            $display("FAIL bp_wr_count: got v=%b wr=%0d want 0/2", bus.m_axi_host_mem_awvalid, wr_outstanding);
        end
        bus.dla_b_ready = 1'b1;
        bus.m_axi_host_mem_bvalid = 1'b1; bus.m_axi_host_mem_bid = 1'b1; bus.m_axi_host_mem_bresp = 2'b00;
        #1;
        n_cmp++;
        if ({bus.dla_b_valid, bus.dla_b_id, bus.m_axi_host_mem_bready} !== 3'b111) begin
            n_err++;
            $display("FAIL b_passthrough: got %b want 111", {bus.dla_b_valid, bus.dla_b_id, bus.m_axi_host_mem_bready});
        end
        repeat (2) @(negedge ap_clk);
        bus.m_axi_host_mem_bvalid = 1'b0;
        n_cmp++;
        if ({wr_outstanding, busy, err_resp} !== 7'd0) begin
            n_err++;
            $display("FAIL bp_drained: got wr=%0d busy=%b err=%b want 0/0/0", wr_outstanding, busy, err_resp);
        end
    endtask

    task automatic test_throttle();
        int acc;
        cfg_base_addr = '0;
        bus.m_axi_host_mem_arready = 1'b1;
        bus.dla_r_ready = 1'b1;
        @(negedge ap_clk);
        bus.dla_ar_valid = 1'b1; bus.dla_ar_len = 8'd0;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            bus.dla_ar_addr = {$urandom, $urandom};
            #1;
            if (bus.dla_ar_ready) acc++;
            @(negedge ap_clk);
        end
        #1;
        n_cmp++;
        if ({acc[5:0], rd_outstanding, bus.dla_ar_ready} !== {6'd16, 5'd16, 1'b0}) begin
            n_err++;
            $display("FAIL throttle_cap: got accepted=%0d rd=%0d ready=%b want 16/16/0", acc, rd_outstanding, bus.dla_ar_ready);
        end
        @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rlast = 1'b1;
        @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rlast = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.dla_ar_ready) acc++;
            @(negedge ap_clk);
        end
        n_cmp++;
        if ({acc[5:0], rd_outstanding} !== {6'd1, 5'd16}) begin
            n_err++;
            $display("FAIL throttle_one_more: got accepted=%0d rd=%0d want 1/16", acc, rd_outstanding);
        end
        bus.dla_ar_valid = 1'b0;
        bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rlast = 1'b1;
        repeat (16) @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rlast = 1'b0;
        n_cmp++;
        if ({rd_outstanding, busy} !== 6'd0) begin
            n_err++;
            $display("FAIL throttle_drain: got rd=%0d busy=%b want 0/0", rd_outstanding, busy);
        end
    endtask

    task automatic test_simultaneous();
        bus.m_axi_host_mem_arready = 1'b1;
        @(negedge ap_clk);
        bus.dla_ar_valid = 1'b1; bus.dla_ar_len = 8'd0;
        repeat (5) @(negedge ap_clk);
        bus.dla_ar_valid = 1'b0;
        @(negedge ap_clk);
        n_cmp++;
        if (rd_outstanding !== 5'd5) begin
            n_err++;
            $display("FAIL simul_setup: got rd=%0d want 5", rd_outstanding);
        end
        bus.m_axi_host_mem_arready = 1'b0;
        bus.dla_ar_valid = 1'b1;
        @(negedge ap_clk);
        bus.dla_ar_valid = 1'b0;
        bus.m_axi_host_mem_arready = 1'b1;
        bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rlast = 1'b1;
        @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rlast = 1'b0;
        n_cmp++;
        if ({rd_outstanding, bus.m_axi_host_mem_arvalid} !== {5'd5, 1'b0}) begin
            n_err++;
            $display("FAIL simul_issue_complete: got rd=%0d v=%b want 5/0", rd_outstanding, bus.m_axi_host_mem_arvalid);
        end
        bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rlast = 1'b1;
        repeat (5) @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rlast = 1'b0;
        n_cmp++;
        if (rd_outstanding !== 5'd0) begin
            n_err++;
            $display("FAIL simul_drain: got rd=%0d want 0", rd_outstanding);
        end
    endtask

    task automatic test_errors();
        bus.m_axi_host_mem_awready = 1'b1;
        bus.dla_b_ready = 1'b1;
        bus.dla_r_ready = 1'b1;
        @(negedge ap_clk);
        bus.dla_aw_valid = 1'b1;
        @(negedge ap_clk);
        bus.dla_aw_valid = 1'b0;
        @(negedge ap_clk);
        bus.m_axi_host_mem_bvalid = 1'b1; bus.m_axi_host_mem_bresp = 2'b10;
        @(negedge ap_clk);
        bus.m_axi_host_mem_bvalid = 1'b0; bus.m_axi_host_mem_bresp = 2'b00;
        n_cmp++;
        if ({err_resp, wr_outstanding} !== {1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL err_bresp: got err=%b wr=%0d want 1/0", err_resp, wr_outstanding);
        end
        err_clr = 1'b1;
        bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rresp = 2'b11; bus.m_axi_host_mem_rlast = 1'b0;
        @(negedge ap_clk);
        err_clr = 1'b0;
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rresp = 2'b00;
        n_cmp++;
        if (err_resp !== 1'b1) begin
            n_err++;
            $display("FAIL err_set_wins: got %b want 1", err_resp);
        end
        err_clr = 1'b1;
        @(negedge ap_clk);
        err_clr = 1'b0;
        n_cmp++;
        if (err_resp !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: got %b want 0", err_resp);
        end
        bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rresp = 2'b10;
        @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rresp = 2'b00;
        n_cmp++;
        if ({err_resp, rd_outstanding} !== {1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL err_rresp: got err=%b rd=%0d want 1/0", err_resp, rd_outstanding);
        end
        err_clr = 1'b1;
        @(negedge ap_clk);
        err_clr = 1'b0;
    endtask

    task automatic test_enable();
        bus.m_axi_host_mem_arready = 1'b0;
        bus.dla_r_ready = 1'b1;
        @(negedge ap_clk);
        bus.dla_ar_valid = 1'b1; bus.dla_ar_len = 8'd1; bus.dla_ar_addr = 64'h200;
        @(negedge ap_clk);
        cfg_enable = 1'b0;
        bus.dla_aw_valid = 1'b1;
        bus.m_axi_host_mem_arready = 1'b1;
        bus.m_axi_host_mem_awready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.dla_ar_ready, bus.dla_aw_ready, bus.m_axi_host_mem_arvalid} !== 3'b001) begin
            n_err++;
            $display("FAIL en_block: got ar_ready=%b aw_ready=%b arvalid=%b want 0/0/1", bus.dla_ar_ready, bus.dla_aw_ready, bus.m_axi_host_mem_arvalid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            n_cmp++;
            if ({bus.m_axi_host_mem_arvalid, bus.m_axi_host_mem_awvalid, rd_outstanding, busy} !== {2'b00, 5'd1, 1'b1}) begin
                n_err++;
                $display("FAIL en_in_flight%0d: got arv=%b awv=%b rd=%0d busy=%b want 0/0/1/1", i, bus.m_axi_host_mem_arvalid, bus.m_axi_host_mem_awvalid, rd_outstanding, busy);
            end
        end
        bus.dla_ar_valid = 1'b0; bus.dla_aw_valid = 1'b0;
        bus.m_axi_host_mem_rvalid = 1'b1; bus.m_axi_host_mem_rlast = 1'b0;
        @(negedge ap_clk);
        bus.m_axi_host_mem_rlast = 1'b1;
        @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rlast = 1'b0;
        n_cmp++;
        if ({rd_outstanding, wr_outstanding, busy} !== 11'd0) begin
            n_err++;
            $display("FAIL en_drained: got rd=%0d wr=%0d busy=%b want 0/0/0", rd_outstanding, wr_outstanding, busy);
        end
        cfg_enable = 1'b1;
    endtask

    task automatic test_random_reads();
        logic [80:0]   exp_q[$];
        logic [80:0]   got;
        logic [AW-1:0] sum;
        int            inflight;
        logic          exp_ready;
        logic          drain;
        inflight = 0;
        bus.dla_r_ready = 1'b1;
        for (int cyc = 0; cyc < 460; cyc++) begin
            @(negedge ap_clk);
            n_cmp++;
            if ({bus.m_axi_host_mem_arvalid, rd_outstanding} !== {exp_q.size() != 0, 5'(inflight)}) begin
                n_err++;
                $display("FAIL rand_state c%0d: got v=%b rd=%0d want v=%b rd=%0d", cyc, bus.m_axi_host_mem_arvalid, rd_outstanding, exp_q.size() != 0, inflight);
            end
            if (exp_q.size() != 0) begin
                got = {bus.m_axi_host_mem_aruser, bus.m_axi_host_mem_araddr, bus.m_axi_host_mem_arlen, bus.m_axi_host_mem_arid};
                n_cmp++;
                if (got !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL rand_ar c%0d: got %h want %h", cyc, got, exp_q[0]);
                end
            end
            drain = (cyc >= 400);
            cfg_enable = drain ? 1'b1 : ($urandom_range(0, 15) != 0);
            cfg_base_addr = {$urandom, $urandom};
            cfg_ctx = 8'($urandom_range(0, 255));
            bus.dla_ar_valid = !drain && ($urandom_range(0, 3) != 0);
            bus.dla_ar_addr = {$urandom, $urandom};
            bus.dla_ar_len = 8'($urandom_range(0, 255));
            bus.dla_ar_id = 1'($urandom_range(0, 1));
            bus.m_axi_host_mem_arready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.m_axi_host_mem_rvalid = (inflight > 0) && (drain || $urandom_range(0, 3) == 0);
            bus.m_axi_host_mem_rlast = 1'b1;
            bus.m_axi_host_mem_rresp = 2'b00;
            #1;
            exp_ready = cfg_enable && (exp_q.size() == 0 || bus.m_axi_host_mem_arready) && (inflight + exp_q.size() < MAXO);
            n_cmp++;
            if (bus.dla_ar_ready !== exp_ready) begin
                n_err++;
                $display("FAIL rand_ready c%0d: got %b want %b (inflight=%0d pending=%0d)", cyc, bus.dla_ar_ready, exp_ready, inflight, exp_q.size());
            end
            if (exp_q.size() != 0 && bus.m_axi_host_mem_arready) begin
                void'(exp_q.pop_front());
                inflight++;
            end
            if (bus.m_axi_host_mem_rvalid) inflight--;
            if (bus.dla_ar_valid && exp_ready) begin
                sum = bus.dla_ar_addr + cfg_base_addr;
                exp_q.push_back({cfg_ctx, sum, bus.dla_ar_len, bus.dla_ar_id});
            end
        end
        @(negedge ap_clk);
        bus.m_axi_host_mem_rvalid = 1'b0; bus.m_axi_host_mem_rlast = 1'b0;
        n_cmp++;
        if ({busy, rd_outstanding} !== 6'd0) begin
            n_err++;
            $display("FAIL rand_final: got busy=%b rd=%0d want 0/0", busy, rd_outstanding);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive_idle();
        test_reset();
        test_read_basic();
        test_wrap_backpressure();
        test_throttle();
        test_simultaneous();
        test_errors();
        test_enable();
        test_random_reads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
